// File: rtl/board_status_arbiter.sv
// Status memory for the 10x10 battleship board. One access port is shared between
// VGA cell fetches and game-logic accesses, and the block also runs full-board clear sweeps.
module board_status_arbiter #(
    parameter int unsigned         GRID_W    = 10,
    parameter int unsigned         GRID_H    = 10,
    parameter int unsigned         STATUS_W  = 5,
    parameter logic [STATUS_W-1:0] FREE_CODE = '0
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic                vga_enable,
    input  logic [3:0]          vga_cell_x,
    input  logic [3:0]          vga_cell_y,
    output logic [STATUS_W-1:0] vga_cell_status,
    input  logic                gl_req,
    input  logic                gl_we,
    input  logic [3:0]          gl_cell_x,
    input  logic [3:0]          gl_cell_y,
    input  logic [STATUS_W-1:0] gl_wdata,
    output logic                gl_ack,
    output logic [STATUS_W-1:0] gl_rdata,
    input  logic                clear_start,
    output logic                clear_busy
);

    localparam int unsigned CELLS      = GRID_W * GRID_H;
    localparam logic [3:0]  MAX_X      = 4'(GRID_W);
    localparam logic [3:0]  MAX_Y      = 4'(GRID_H);
    localparam logic [6:0]  ROW_STRIDE = 7'(GRID_W);
    localparam logic [6:0]  LAST_IDX   = 7'(CELLS - 1);

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_t;

    state_t                state_q, state_d;
    logic [6:0]            sweep_idx_q, sweep_idx_d;
    logic                  cache_valid_q, cache_valid_d;
    logic [3:0]            cache_x_q, cache_x_d;
    logic [3:0]            cache_y_q, cache_y_d;
    logic [STATUS_W-1:0]   vga_status_q, vga_status_d;
    logic                  ack_q, ack_d;
    logic [STATUS_W-1:0]   rdata_q, rdata_d;

    logic [STATUS_W-1:0]   mem [CELLS];
    logic                  mem_we;
    logic [6:0]            mem_waddr;
    logic [STATUS_W-1:0]   mem_wdata;

    logic                  vga_in_range;
    logic                  gl_in_range;
    logic [6:0]            vga_idx;
    logic [6:0]            gl_idx;
    logic                  vga_need;
    logic                  gl_hits_cache;

    assign vga_in_range  = (vga_cell_x < MAX_X) && (vga_cell_y < MAX_Y);
    assign gl_in_range   = (gl_cell_x < MAX_X) && (gl_cell_y < MAX_Y);
    assign vga_idx       = 7'(vga_cell_y) * ROW_STRIDE + 7'(vga_cell_x);
    assign gl_idx        = 7'(gl_cell_y) * ROW_STRIDE + 7'(gl_cell_x);
    // Out-of-range cells still consume a fetch slot, so the need test is coordinate-based only.
    assign vga_need      = vga_enable &&
                           (!cache_valid_q || (vga_cell_x != cache_x_q) || (vga_cell_y != cache_y_q));
    assign gl_hits_cache = cache_valid_q && (gl_cell_x == cache_x_q) && (gl_cell_y == cache_y_q);

    always_comb begin
        state_d       = state_q;
        sweep_idx_d   = sweep_idx_q;
        cache_valid_d = cache_valid_q;
        cache_x_d     = cache_x_q;
        cache_y_d     = cache_y_q;
        vga_status_d  = vga_status_q;
        ack_d         = 1'b0;
        rdata_d       = rdata_q;
        mem_we        = 1'b0;
        mem_waddr     = sweep_idx_q;
        mem_wdata     = FREE_CODE;

        case (state_q)
            ST_CLEAR: begin
                mem_we       = 1'b1;
                vga_status_d = FREE_CODE;
                if (sweep_idx_q == LAST_IDX) begin
                    state_d       = ST_RUN;
                    sweep_idx_d   = '0;
                    cache_valid_d = 1'b0;
                end else begin
                    sweep_idx_d = sweep_idx_q + 7'd1;
                end
            end

            ST_RUN: begin
                if (clear_start) begin
                    state_d       = ST_CLEAR;
                    sweep_idx_d   = '0;
                    cache_valid_d = 1'b0;
                    vga_status_d  = FREE_CODE;
                end else if (vga_need) begin
                    vga_status_d  = vga_in_range ? mem[vga_idx] : FREE_CODE;
                    cache_x_d     = vga_cell_x;
                    cache_y_d     = vga_cell_y;
                    cache_valid_d = 1'b1;
                end else if (gl_req && !ack_q) begin
                    ack_d = 1'b1;
                    if (gl_we) begin
                        if (gl_in_range) begin
                            mem_we    = 1'b1;
                            mem_waddr = gl_idx;
                            mem_wdata = gl_wdata;
                            if (gl_hits_cache) begin
                                cache_valid_d = 1'b0;
                            end
                        end
                    end else begin
                        rdata_d = gl_in_range ? mem[gl_idx] : FREE_CODE;
                    end
                end
            end

            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q       <= ST_CLEAR;
            sweep_idx_q   <= '0;
            cache_valid_q <= 1'b0;
            cache_x_q     <= '0;
            cache_y_q     <= '0;
            vga_status_q  <= FREE_CODE;
            ack_q         <= 1'b0;
            rdata_q       <= '0;
        end else begin
            state_q       <= state_d;
            sweep_idx_q   <= sweep_idx_d;
            cache_valid_q <= cache_valid_d;
            cache_x_q     <= cache_x_d;
            cache_y_q     <= cache_y_d;
            vga_status_q  <= vga_status_d;
            ack_q         <= ack_d;
            rdata_q       <= rdata_d;
        end
    end

    // Board contents need no reset: the CLEAR state initialises every cell after reset.
    always_ff @(posedge clk_in) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign vga_cell_status = vga_status_q;
    assign gl_ack          = ack_q;
    assign gl_rdata        = rdata_q;
    assign clear_busy      = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_board_status_arbiter.sv
// Self-checking bench for board_status_arbiter: directed scenarios plus randomized
// VGA/game-logic traffic checked against a flat board model.
module tb_board_status_arbiter;

    logic       clk_in = 1'b0;
    logic       rst_n_in = 1'b0;
    logic       vga_enable = 1'b0;
    logic [3:0] vga_cell_x = '0;
    logic [3:0] vga_cell_y = '0;
    logic [4:0] vga_cell_status;
    logic       gl_req = 1'b0;
    logic       gl_we = 1'b0;
    logic [3:0] gl_cell_x = '0;
    logic [3:0] gl_cell_y = '0;
    logic [4:0] gl_wdata = '0;
    logic       gl_ack;
    logic [4:0] gl_rdata;
    logic       clear_start = 1'b0;
    logic       clear_busy;

    int tests_run = 0;
    int tests_failed = 0;

    logic [4:0] model_mem [100];

    board_status_arbiter #(
        .GRID_W   (10),
        .GRID_H   (10),
        .STATUS_W (5),
        .FREE_CODE(5'd0)
    ) dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .vga_enable     (vga_enable),
        .vga_cell_x     (vga_cell_x),
        .vga_cell_y     (vga_cell_y),
        .vga_cell_status(vga_cell_status),
        .gl_req         (gl_req),
        .gl_we          (gl_we),
        .gl_cell_x      (gl_cell_x),
        .gl_cell_y      (gl_cell_y),
        .gl_wdata       (gl_wdata),
        .gl_ack         (gl_ack),
        .gl_rdata       (gl_rdata),
        .clear_start    (clear_start),
        .clear_busy     (clear_busy)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [4:0] model_cell(input int x, input int y);
        if (x < 10 && y < 10) return model_mem[y * 10 + x];
        return 5'd0;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 100; i++) model_mem[i] = 5'd0;
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // One game-logic transaction; lat = cycles from request to ack, -1 on timeout.
    task automatic gl_xfer(input logic we, input int x, input int y, input logic [4:0] wd,
                           output int lat, output logic [4:0] rd);
        gl_we     = we;
        gl_cell_x = 4'(x);
        gl_cell_y = 4'(y);
        gl_wdata  = wd;
        gl_req    = 1'b1;
        lat       = -1;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (gl_ack) begin
                lat = k;
                break;
            end
        end
        rd     = gl_rdata;
        gl_req = 1'b0;
        if (we && lat > 0 && x < 10 && y < 10) model_mem[y * 10 + x] = wd;
        step();
    endtask

    task automatic test_reset();
        int cnt;
        int early_ack;
        int lat;
        rst_n_in = 1'b0;
        step();
        step();
        tests_run++;
        if (clear_busy !== 1'b1) begin tests_failed++; $display("FAIL reset_busy: got %0b expected 1", clear_busy); end
        tests_run++;
        if (gl_ack !== 1'b0) begin tests_failed++; $display("FAIL reset_ack: got %0b expected 0", gl_ack); end
        tests_run++;
        if (gl_rdata !== 5'd0) begin tests_failed++; $display("FAIL reset_rdata: got %0d expected 0", gl_rdata); end
        tests_run++;
        if (vga_cell_status !== 5'd0) begin tests_failed++; $display("FAIL reset_vga: got %0d expected 0", vga_cell_status); end

        gl_we     = 1'b0;
        gl_cell_x = 4'd3;
        gl_cell_y = 4'd4;
        gl_req    = 1'b1;
        rst_n_in  = 1'b1;
        cnt       = 0;
        early_ack = 0;
        while (clear_busy && cnt < 200) begin
            step();
            cnt++;
            if (gl_ack) early_ack++;
        end
        tests_run++;
        if (cnt != 100) begin tests_failed++; $display("FAIL reset_sweep_len: got %0d expected 100", cnt); end
        tests_run++;
        if (early_ack != 0) begin tests_failed++; $display("FAIL reset_ack_during_clear: got %0d expected 0", early_ack); end
        lat = -1;
        for (int k = 1; k <= 5; k++) begin
            step();
            if (gl_ack) begin lat = k; break; end
        end
        tests_run++;
        if (lat != 1) begin tests_failed++; $display("FAIL t1_latency: got %0d expected 1", lat); end
        tests_run++;
        if (gl_rdata !== 5'd0) begin tests_failed++; $display("FAIL t1_rdata: got %0d expected 0", gl_rdata); end
        gl_req = 1'b0;
        step();
        model_clear();
    endtask

    task automatic test_write_read();
        int lat;
        logic [4:0] rd;
        vga_enable = 1'b0;
        gl_xfer(1'b1, 2, 5, 5'd3, lat, rd);
        tests_run++;
        if (lat != 1) begin tests_failed++; $display("FAIL t2_write_latency: got %0d expected 1", lat); end
        gl_xfer(1'b0, 2, 5, 5'd0, lat, rd);
        tests_run++;
        if (lat != 1) begin tests_failed++; $display("FAIL t2_read_latency: got %0d expected 1", lat); end
        tests_run++;
        if (rd !== model_cell(2, 5)) begin tests_failed++; $display("FAIL t2_read_data: got %0d expected %0d", rd, model_cell(2, 5)); end
    endtask

    task automatic test_vga_fetch();
        int lat;
        logic [4:0] rd;
        logic [4:0] held;
        gl_xfer(1'b1, 7, 1, 5'd4, lat, rd);
        vga_enable = 1'b1;
        vga_cell_x = 4'd7;
        vga_cell_y = 4'd1;
        step();
        tests_run++;
        if (vga_cell_status !== model_cell(7, 1)) begin tests_failed++; $display("FAIL t3_vga_fetch: got %0d expected %0d", vga_cell_status, model_cell(7, 1)); end
        vga_cell_x = 4'd8;
        step();
        tests_run++;
        if (vga_cell_status !== model_cell(8, 1)) begin tests_failed++; $display("FAIL t3_vga_move: got %0d expected %0d", vga_cell_status, model_cell(8, 1)); end
        held       = model_cell(8, 1);
        vga_enable = 1'b0;
        vga_cell_x = 4'd7;
        step();
        step();
        tests_run++;
        if (vga_cell_status !== held) begin tests_failed++; $display("FAIL vga_disabled_hold: got %0d expected %0d", vga_cell_status, held); end
    endtask

    task automatic test_collision();
        vga_enable = 1'b1;
        vga_cell_x = 4'd2;
        vga_cell_y = 4'd5;
        step();
        step();
        vga_cell_x = 4'd7;
        vga_cell_y = 4'd1;
        gl_we      = 1'b0;
        gl_cell_x  = 4'd2;
        gl_cell_y  = 4'd5;
        gl_req     = 1'b1;
        step();
        tests_run++;
        if (vga_cell_status !== model_cell(7, 1)) begin tests_failed++; $display("FAIL t4_vga_first: got %0d expected %0d", vga_cell_status, model_cell(7, 1)); end
        tests_run++;
        if (gl_ack !== 1'b0) begin tests_failed++; $display("FAIL t4_ack_deferred: got %0b expected 0", gl_ack); end
        step();
        tests_run++;
        if (gl_ack !== 1'b1) begin tests_failed++; $display("FAIL t4_ack_t2: got %0b expected 1", gl_ack); end
        tests_run++;
        if (gl_rdata !== model_cell(2, 5)) begin tests_failed++; $display("FAIL t4_rdata: got %0d expected %0d", gl_rdata, model_cell(2, 5)); end
        gl_req = 1'b0;
        step();
    endtask

    task automatic test_cache_invalidate();
        int lat;
        int w;
        logic [4:0] rd;
        vga_enable = 1'b1;
        vga_cell_x = 4'd0;
        vga_cell_y = 4'd0;
        step();
        step();
        tests_run++;
        if (vga_cell_status !== 5'd0) begin tests_failed++; $display("FAIL t5_vga_initial: got %0d expected 0", vga_cell_status); end
        gl_xfer(1'b1, 0, 0, 5'd2, lat, rd);
        tests_run++;
        if (lat != 1) begin tests_failed++; $display("FAIL t5_write_latency: got %0d expected 1", lat); end
        w = 0;
        while (vga_cell_status !== 5'd2 && w < 2) begin
            step();
            w++;
        end
        tests_run++;
        if (vga_cell_status !== 5'd2) begin tests_failed++; $display("FAIL t5_vga_refetch: got %0d expected 2", vga_cell_status); end
    endtask

    task automatic test_out_of_range();
        int lat;
        logic [4:0] rd;
        vga_enable = 1'b0;
        gl_xfer(1'b1, 10, 0, 5'd7, lat, rd);
        tests_run++;
        if (lat != 1) begin tests_failed++; $display("FAIL oor_write_latency: got %0d expected 1", lat); end
        gl_xfer(1'b0, 0, 1, 5'd0, lat, rd);
        tests_run++;
        if (rd !== model_cell(0, 1)) begin tests_failed++; $display("FAIL oor_alias_unchanged: got %0d expected %0d", rd, model_cell(0, 1)); end
        gl_xfer(1'b0, 2, 5, 5'd0, lat, rd);
        gl_xfer(1'b0, 10, 0, 5'd0, lat, rd);
        tests_run++;
        if (rd !== 5'd0) begin tests_failed++; $display("FAIL oor_read_free: got %0d expected 0", rd); end
        vga_enable = 1'b1;
        vga_cell_x = 4'd12;
        vga_cell_y = 4'd3;
        step();
        tests_run++;
        if (vga_cell_status !== 5'd0) begin tests_failed++; $display("FAIL oor_vga_free: got %0d expected 0", vga_cell_status); end
        vga_cell_y = 4'd4;
        gl_we      = 1'b0;
        gl_cell_x  = 4'd2;
        gl_cell_y  = 4'd5;
        gl_req     = 1'b1;
        step();
        tests_run++;
        if (gl_ack !== 1'b0) begin tests_failed++; $display("FAIL oor_vga_slot: got %0b expected 0", gl_ack); end
        step();
        tests_run++;
        if (gl_ack !== 1'b1 || gl_rdata !== model_cell(2, 5)) begin tests_failed++; $display("FAIL oor_vga_slot_ack: got ack %0b data %0d expected ack 1 data %0d", gl_ack, gl_rdata, model_cell(2, 5)); end
        gl_req = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        logic exp_ack;
        vga_enable = 1'b0;
        gl_we      = 1'b0;
        gl_cell_x  = 4'd7;
        gl_cell_y  = 4'd1;
        gl_req     = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            exp_ack = (k % 2) == 1;
            tests_run++;
            if (gl_ack !== exp_ack) begin tests_failed++; $display("FAIL back_to_back_ack[%0d]: got %0b expected %0b", k, gl_ack, exp_ack); end
        end
        tests_run++;
        if (gl_rdata !== model_cell(7, 1)) begin tests_failed++; $display("FAIL back_to_back_rdata: got %0d expected %0d", gl_rdata, model_cell(7, 1)); end
        gl_req = 1'b0;
        step();
    endtask

    task automatic test_random_mixed();
        int cur_x;
        int cur_y;
        int nx, ny, gx, gy, lat, exp_lat;
        logic we;
        logic [4:0] wd, rd, vga1, exp_vga1, exp_rd;
        vga_enable = 1'b1;
        vga_cell_x = 4'd0;
        vga_cell_y = 4'd0;
        cur_x      = 0;
        cur_y      = 0;
        step();
        step();
        for (int it = 0; it < 40; it++) begin
            nx       = int'($urandom_range(0, 11));
            ny       = int'($urandom_range(0, 11));
            gx       = int'($urandom_range(0, 11));
            gy       = int'($urandom_range(0, 11));
            we       = 1'($urandom_range(0, 1));
            wd       = 5'($urandom_range(0, 31));
            exp_vga1 = model_cell(nx, ny);
            exp_rd   = model_cell(gx, gy);
            exp_lat  = (nx != cur_x || ny != cur_y) ? 2 : 1;
            vga_cell_x = 4'(nx);
            vga_cell_y = 4'(ny);
            gl_we      = we;
            gl_cell_x  = 4'(gx);
            gl_cell_y  = 4'(gy);
            gl_wdata   = wd;
            gl_req     = 1'b1;
            lat        = -1;
            rd         = '0;
            vga1       = '0;
            for (int k = 1; k <= 4; k++) begin
                step();
                if (k == 1) vga1 = vga_cell_status;
                if (gl_req && gl_ack) begin
                    lat    = k;
                    rd     = gl_rdata;
                    gl_req = 1'b0;
                end
            end
            gl_req = 1'b0;
            if (we && gx < 10 && gy < 10 && lat > 0) model_mem[gy * 10 + gx] = wd;
            tests_run++;
            if (vga1 !== exp_vga1) begin tests_failed++; $display("FAIL mixed_vga_first[%0d]: got %0d expected %0d", it, vga1, exp_vga1); end
            tests_run++;
            if (lat != exp_lat) begin tests_failed++; $display("FAIL mixed_latency[%0d]: got %0d expected %0d", it, lat, exp_lat); end
            if (!we) begin
                tests_run++;
                if (rd !== exp_rd) begin tests_failed++; $display("FAIL mixed_rdata[%0d]: got %0d expected %0d", it, rd, exp_rd); end
            end
            tests_run++;
            if (vga_cell_status !== model_cell(nx, ny)) begin tests_failed++; $display("FAIL mixed_vga_settled[%0d]: got %0d expected %0d", it, vga_cell_status, model_cell(nx, ny)); end
            cur_x = nx;
            cur_y = ny;
        end
    endtask

    task automatic test_clear_pending();
        int lat;
        int cnt;
        int early_ack;
        logic [4:0] rd;
        vga_enable = 1'b1;
        gl_xfer(1'b1, 1, 1, 5'd9, lat, rd);
        vga_cell_x = 4'd1;
        vga_cell_y = 4'd1;
        step();
        step();
        tests_run++;
        if (vga_cell_status !== 5'd9) begin tests_failed++; $display("FAIL clear_pre_vga: got %0d expected 9", vga_cell_status); end
        clear_start = 1'b1;
        gl_we       = 1'b0;
        gl_cell_x   = 4'd1;
        gl_cell_y   = 4'd1;
        gl_req      = 1'b1;
        step();
        clear_start = 1'b0;
        tests_run++;
        if (clear_busy !== 1'b1) begin tests_failed++; $display("FAIL clear_busy_start: got %0b expected 1", clear_busy); end
        tests_run++;
        if (vga_cell_status !== 5'd0) begin tests_failed++; $display("FAIL clear_vga_forced: got %0d expected 0", vga_cell_status); end
        cnt       = 0;
        early_ack = gl_ack ? 1 : 0;
        while (clear_busy && cnt < 200) begin
            clear_start = (cnt == 50);
            step();
            cnt++;
            if (gl_ack) early_ack++;
        end
        clear_start = 1'b0;
        tests_run++;
        if (cnt != 100) begin tests_failed++; $display("FAIL clear_sweep_len: got %0d expected 100", cnt); end
        tests_run++;
        if (early_ack != 0) begin tests_failed++; $display("FAIL clear_ack_during_sweep: got %0d expected 0", early_ack); end
        model_clear();
        lat = -1;
        for (int k = 1; k <= 5; k++) begin
            step();
            if (gl_ack) begin lat = k; break; end
        end
        tests_run++;
        if (lat < 1 || lat > 2) begin tests_failed++; $display("FAIL clear_pending_ack: got latency %0d expected 1..2", lat); end
        tests_run++;
        if (gl_rdata !== 5'd0) begin tests_failed++; $display("FAIL clear_pending_rdata: got %0d expected 0", gl_rdata); end
        gl_req = 1'b0;
        step();
        step();
        tests_run++;
        if (vga_cell_status !== 5'd0) begin tests_failed++; $display("FAIL clear_vga_after: got %0d expected 0", vga_cell_status); end
    endtask

    task automatic test_reset_mid_sweep();
        int lat;
        int cnt;
        logic [4:0] rd;
        vga_enable = 1'b0;
        gl_xfer(1'b1, 4, 4, 5'd6, lat, rd);
        gl_xfer(1'b0, 4, 4, 5'd0, lat, rd);
        tests_run++;
        if (rd !== 5'd6) begin tests_failed++; $display("FAIL pre_reset_read: got %0d expected 6", rd); end
        clear_start = 1'b1;
        step();
        clear_start = 1'b0;
        for (int k = 0; k < 30; k++) step();
        #2;
        rst_n_in = 1'b0;
        #1;
        tests_run++;
        if (gl_rdata !== 5'd0) begin tests_failed++; $display("FAIL async_reset_rdata: got %0d expected 0", gl_rdata); end
        tests_run++;
        if (clear_busy !== 1'b1) begin tests_failed++; $display("FAIL async_reset_busy: got %0b expected 1", clear_busy); end
        step();
        rst_n_in = 1'b1;
        cnt      = 0;
        while (clear_busy && cnt < 200) begin
            step();
            cnt++;
        end
        tests_run++;
        if (cnt != 100) begin tests_failed++; $display("FAIL reset_restart_len: got %0d expected 100", cnt); end
        model_clear();
        gl_xfer(1'b0, 4, 4, 5'd0, lat, rd);
        tests_run++;
        if (rd !== 5'd0) begin tests_failed++; $display("FAIL post_reset_cleared: got %0d expected 0", rd); end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_write_read();
        test_vga_fetch();
        test_collision();
        test_cache_invalidate();
        test_out_of_range();
        test_back_to_back();
        test_random_mixed();
        test_clear_pending();
        test_reset_mid_sweep();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
